// File: rtl/noc_tpram_pipe.sv
// noc_tpram_pipe: parametrised single-clock two-port RAM for the iDMA/data-NoC
// buffers. Write port takes per-lane active-low masks; the read port returns a
// registered word after 1 or 2 cycles with a one-cycle rvalid strobe.
// Same-address read-during-write returns new data (RDW_MODE=1) or old data
// (RDW_MODE=0). Out-of-range writes are dropped and out-of-range reads return
// zero but still produce rvalid. The array is a behavioural model and is not
// reset; only the output pipeline flops are reset.

module noc_tpram_pipe #(
  parameter int DW       = 288,
  parameter int LANE_W   = 36,
  parameter int DEPTH    = 64,
  parameter int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int READ_LAT = 1,
  parameter int RDW_MODE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // read port
  input  logic                 rceb,
  input  logic [AW-1:0]        raddr,
  output logic [DW-1:0]        rdata,
  output logic                 rvalid,
  // write port
  input  logic                 wceb,
  input  logic [AW-1:0]        waddr,
  input  logic [DW/LANE_W-1:0] wmask_n,
  input  logic [DW-1:0]        wdata
);

  localparam int unsigned NL = DW / LANE_W;

  // DEPTH at AW+1 bits so the range check works for any DEPTH, pow2 or not
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  // Elaboration-time parameter sanity
  if (DW % LANE_W != 0) begin : g_chk_dw
    $fatal(1, "noc_tpram_pipe: DW must be a multiple of LANE_W");
  end
  if (READ_LAT != 1 && READ_LAT != 2) begin : g_chk_lat
    $fatal(1, "noc_tpram_pipe: READ_LAT must be 1 or 2");
  end

  logic [DW-1:0] r_mem [DEPTH];

  logic          w_wr_en;
  logic          w_rd_inrange;
  logic          w_rdw_hit;
  logic [DW-1:0] w_rd_old;
  logic [DW-1:0] w_rd_word;

  logic [DW-1:0] r_s1_data;
  logic          r_s1_valid;

  assign w_wr_en      = !wceb && ({1'b0, waddr} < DEPTH_C);
  assign w_rd_inrange = {1'b0, raddr} < DEPTH_C;
  assign w_rdw_hit    = w_wr_en && !rceb && (raddr == waddr);
  assign w_rd_old     = w_rd_inrange ? r_mem[raddr] : '0;

  // Lane-masked write into the array; dropped when the address is out of range
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NL; i++) begin
      if (w_wr_en && !wmask_n[i]) begin
        r_mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
      end
    end
  end

  // Read word selection; write-first mode forwards the lanes being written
  always_comb begin
    w_rd_word = w_rd_old;
    if (RDW_MODE == 1 && w_rdw_hit) begin
      for (int unsigned i = 0; i < NL; i++) begin
        if (!wmask_n[i]) begin
          w_rd_word[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Stage-1 read register: capture on a read, hold data otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_data  <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= !rceb;
      if (!rceb) begin
        r_s1_data <= w_rd_word;
      end
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic [DW-1:0] r_s2_data;
    logic          r_s2_valid;

    // Stage-2 register: only loads on a completed stage-1 read so rdata holds
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s2_data  <= '0;
        r_s2_valid <= 1'b0;
      end else begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_data <= r_s1_data;
        end
      end
    end

    assign rdata  = r_s2_data;
    assign rvalid = r_s2_valid;
  end else begin : g_lat1
    assign rdata  = r_s1_data;
    assign rvalid = r_s1_valid;
  end

endmodule

// File: tb/tb_noc_tpram_pipe.sv
// Self-checking bench for noc_tpram_pipe. Two instances share the stimulus:
//   u_a: DEPTH=64, READ_LAT=1, RDW_MODE=1
//   u_b: DEPTH=48, READ_LAT=2, RDW_MODE=0
// A scheduled-delivery reference model checks both every cycle; a vector
// table and hand-written sequences cover the directed scenarios.

module tb_noc_tpram_pipe;

  localparam int DW = 288;
  localparam int LW = 36;
  localparam int NL = 8;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rceb = 1'b1;
  logic          wceb = 1'b1;
  logic [AW-1:0] raddr = '0;
  logic [AW-1:0] waddr = '0;
  logic [NL-1:0] wmask_n = '1;
  logic [DW-1:0] wdata = '0;

  logic [DW-1:0] rdata_a, rdata_b;
  logic          rvalid_a, rvalid_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  noc_tpram_pipe #(.DW(DW), .LANE_W(LW), .DEPTH(64), .READ_LAT(1), .RDW_MODE(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .rceb(rceb), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a),
    .wceb(wceb), .waddr(waddr), .wmask_n(wmask_n), .wdata(wdata)
  );

  noc_tpram_pipe #(.DW(DW), .LANE_W(LW), .DEPTH(48), .READ_LAT(2), .RDW_MODE(0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .rceb(rceb), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b),
    .wceb(wceb), .waddr(waddr), .wmask_n(wmask_n), .wdata(wdata)
  );

  task automatic chk(input string nm, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp, input logic [DW-1:0] care);
    checks++;
    if ((got & care) !== (exp & care)) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, got & care, exp & care);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int dep(input int k);
    return (k == 0) ? 64 : 48;
  endfunction
  function automatic int lat(input int k);
    return (k == 0) ? 1 : 2;
  endfunction
  function automatic int rdw(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  logic [DW-1:0] m_mem [2][64];
  logic [NL-1:0] m_kn  [2][64];   // lanes of each word with defined contents
  logic          pv    [2][4];    // delivery slots indexed by due cycle mod 4
  logic [DW-1:0] pd    [2][4];
  logic [NL-1:0] pk    [2][4];
  logic [DW-1:0] last_d [2];
  logic [NL-1:0] last_k [2];
  int unsigned   cyc = 0;

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 64; a++) begin
        m_mem[k][a] = '0;
        m_kn[k][a]  = '0;
      end
      for (int s = 0; s < 4; s++) begin
        pv[k][s] = 1'b0;
        pd[k][s] = '0;
        pk[k][s] = '0;
      end
      last_d[k] = '0;
      last_k[k] = '1;
    end
  end

  // Model update: schedule read results for delivery, then apply writes
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [DW-1:0] d;
      logic [NL-1:0] kn;
      int            slot;
      if (rst_n && !rceb) begin
        if (int'(raddr) >= dep(k)) begin
          d  = '0;
          kn = '1;
        end else begin
          d  = m_mem[k][raddr];
          kn = m_kn[k][raddr];
          if (rdw(k) == 1 && !wceb && waddr == raddr) begin
            for (int l = 0; l < NL; l++) begin
              if (!wmask_n[l]) begin
                d[l*LW +: LW] = wdata[l*LW +: LW];
                kn[l] = 1'b1;
              end
            end
          end
        end
        slot = int'((cyc + lat(k)) % 4);
        pv[k][slot] = 1'b1;
        pd[k][slot] = d;
        pk[k][slot] = kn;
      end
      if (!wceb && int'(waddr) < dep(k)) begin
        for (int l = 0; l < NL; l++) begin
          if (!wmask_n[l]) begin
            m_mem[k][waddr][l*LW +: LW] = wdata[l*LW +: LW];
            m_kn[k][waddr][l] = 1'b1;
          end
        end
      end
    end
    cyc++;
  end

  // Model check: every cycle compare rvalid and the defined lanes of rdata
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic          ev;
      logic [DW-1:0] care;
      int            s;
      if (!rst_n) begin
        for (int j = 0; j < 4; j++) pv[k][j] = 1'b0;
        last_d[k] = '0;
        last_k[k] = '1;
        ev = 1'b0;
      end else begin
        s  = int'(cyc % 4);
        ev = pv[k][s];
        if (ev) begin
          last_d[k] = pd[k][s];
          last_k[k] = pk[k][s];
          pv[k][s]  = 1'b0;
        end
      end
      care = '0;
      for (int l = 0; l < NL; l++) if (last_k[k][l]) care[l*LW +: LW] = '1;
      if (k == 0) begin
        chk("model_rvalid_a", DW'(rvalid_a), DW'(ev), '1);
        chk("model_rdata_a", rdata_a, last_d[k], care);
      end else begin
        chk("model_rvalid_b", DW'(rvalid_b), DW'(ev), '1);
        chk("model_rdata_b", rdata_b, last_d[k], care);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic rc, input logic [AW-1:0] ra, input logic wc,
                      input logic [AW-1:0] wa, input logic [NL-1:0] m,
                      input logic [DW-1:0] wd);
    rceb = rc; raddr = ra; wceb = wc; waddr = wa; wmask_n = m; wdata = wd;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b1, '0, 1'b1, '0, '1, '0);
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  typedef struct {
    logic          rc;
    logic [AW-1:0] ra;
    logic          wc;
    logic [AW-1:0] wa;
    logic [NL-1:0] m;
    logic [DW-1:0] wd;
    logic          ev;
    logic [DW-1:0] ed;
  } vec_t;

  function automatic vec_t mk(input logic rc, input logic [AW-1:0] ra, input logic wc,
                              input logic [AW-1:0] wa, input logic [NL-1:0] m,
                              input logic [DW-1:0] wd, input logic ev,
                              input logic [DW-1:0] ed);
    vec_t v;
    v.rc = rc; v.ra = ra; v.wc = wc; v.wa = wa; v.m = m; v.wd = wd;
    v.ev = ev; v.ed = ed;
    return v;
  endfunction

  // ---------------- main sequence ----------------
  logic [DW-1:0] P_A5, P1, P2, MERGED, LANE0Z, W47, W50;
  logic [DW-1:0] sw [4];
  vec_t          tbl [10];

  initial begin
    P_A5   = {36{8'hA5}};
    P1     = {72{4'h1}};
    P2     = {72{4'h2}};
    MERGED = {P1[DW-1:144], P2[143:0]};
    LANE0Z = {{(DW-LW){1'b1}}, {LW{1'b0}}};

    tbl[0] = mk(1, 0, 0, 3,  8'h00, P_A5, 0, '0);
    tbl[1] = mk(0, 3, 1, 0,  8'hFF, '0,   1, P_A5);
    tbl[2] = mk(1, 0, 1, 0,  8'hFF, '0,   0, P_A5);
    tbl[3] = mk(1, 0, 0, 10, 8'h00, '1,   0, P_A5);
    tbl[4] = mk(1, 0, 0, 10, 8'hFE, '0,   0, P_A5);
    tbl[5] = mk(0, 10, 1, 0, 8'hFF, '0,   1, LANE0Z);
    tbl[6] = mk(1, 0, 0, 5,  8'h00, P1,   0, LANE0Z);
    tbl[7] = mk(0, 5, 0, 5,  8'hF0, P2,   1, MERGED);
    tbl[8] = mk(0, 5, 1, 0,  8'hFF, '0,   1, MERGED);
    tbl[9] = mk(1, 0, 1, 0,  8'hFF, '0,   0, MERGED);

    // reset state while the clock runs
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rvalid_a", DW'(rvalid_a), '0, '1);
    chk("rst_rdata_a", rdata_a, '0, '1);
    chk("rst_rvalid_b", DW'(rvalid_b), '0, '1);
    chk("rst_rdata_b", rdata_b, '0, '1);
    rst_n = 1'b1;

    // vector table against u_a (latency 1, write-first)
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rc, tbl[i].ra, tbl[i].wc, tbl[i].wa, tbl[i].m, tbl[i].wd);
      chk($sformatf("tbl%0d_rvalid_a", i), DW'(rvalid_a), DW'(tbl[i].ev), '1);
      chk($sformatf("tbl%0d_rdata_a", i), rdata_a, tbl[i].ed, '1);
    end

    // read-during-write, old-data mode on u_b (latency 2)
    step(1, 0, 0, 7, 8'h00, P1);
    step(0, 7, 0, 7, 8'hF0, P2);
    step(0, 7, 1, 0, 8'hFF, '0);
    chk("rdw0_rvalid_b", DW'(rvalid_b), DW'(1), '1);
    chk("rdw0_old_b", rdata_b, P1, '1);
    idle();
    chk("rdw0_next_rvalid_b", DW'(rvalid_b), DW'(1), '1);
    chk("rdw0_merged_b", rdata_b, MERGED, '1);
    idle();
    chk("rdw0_idle_rvalid_b", DW'(rvalid_b), '0, '1);

    // latency-2 streaming, addrs 0..3 back to back
    for (int i = 0; i < 4; i++) begin
      sw[i] = rnd_word();
      step(1, 0, 0, AW'(i), 8'h00, sw[i]);
    end
    idle();
    for (int k = 0; k < 7; k++) begin
      if (k < 4) step(0, AW'(k), 1, 0, 8'hFF, '0);
      else idle();
      chk($sformatf("stream%0d_rvalid_b", k), DW'(rvalid_b),
          DW'((k >= 1 && k <= 4) ? 1 : 0), '1);
      if (k >= 1) chk($sformatf("stream%0d_rdata_b", k), rdata_b, sw[(k >= 4) ? 3 : k - 1], '1);
    end

    // address boundary on the DEPTH=48 instance
    W47 = rnd_word();
    W50 = rnd_word();
    step(1, 0, 0, 47, 8'h00, W47);
    step(1, 0, 0, 50, 8'h00, W50);
    step(0, 47, 1, 0, 8'hFF, '0);
    step(0, 50, 1, 0, 8'hFF, '0);
    chk("bnd47_rvalid_b", DW'(rvalid_b), DW'(1), '1);
    chk("bnd47_rdata_b", rdata_b, W47, '1);
    step(0, 47, 1, 0, 8'hFF, '0);
    chk("bnd50_rvalid_b", DW'(rvalid_b), DW'(1), '1);
    chk("bnd50_rdata_b", rdata_b, '0, '1);
    idle();
    chk("bnd47again_rdata_b", rdata_b, W47, '1);
    idle();

    // reset asserted while a latency-2 read is in flight
    step(0, 3, 1, 0, 8'hFF, '0);
    rceb = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_rvalid_b", DW'(rvalid_b), '0, '1);
    chk("rstmid_rdata_b", rdata_b, '0, '1);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rstmid2_rvalid_b", DW'(rvalid_b), '0, '1);
    chk("rstmid2_rdata_b", rdata_b, '0, '1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk($sformatf("rstpost%0d_rvalid_b", i), DW'(rvalid_b), '0, '1);
      chk($sformatf("rstpost%0d_rdata_b", i), rdata_b, '0, '1);
    end

    // randomized traffic against the model, with one reset pulse
    for (int i = 0; i < 600; i++) begin
      logic [AW-1:0] ra, wa;
      ra = AW'($urandom_range(63));
      wa = ($urandom_range(3) == 0) ? ra : AW'($urandom_range(63));
      if (i == 300) begin
        rst_n = 1'b0;
        idle();
        idle();
        rst_n = 1'b1;
      end
      step(logic'($urandom_range(1)), ra, logic'($urandom_range(1)), wa,
           NL'($urandom), rnd_word());
    end
    repeat (4) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
